// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     - state_t : FSM state encoding (S_IDLE=0, S_SHIFT=1, S_DONE=2)
//     - cnt_width() : width of the bit counter for a given operand width
//   No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // The counter only has to reach width-1, so $clog2(width) bits suffice.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// -----------------------------------------------------------------------------
// fa
//   One-bit full adder cell (purely combinational).
//   Ports:
//     a, b  in  1  addend bits
//     cin   in  1  carry in
//     sum   out 1  a ^ b ^ cin
//     cout  out 1  majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Captures a/b/cin on an accepted start, feeds one
//   LSB pair per cycle through a single full adder cell, recirculates the carry
//   and shifts the sum bits into a result register.
//   Ports:
//     clk    in   1      clock, rising edge
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      load operands and begin an add (accepted in IDLE/DONE)
//     a, b   in   WIDTH  operands
//     cin    in   1      carry in
//     busy   out  1      high while bits are being added
//     done   out  1      one-cycle pulse when sum/cout/ovf are updated
//     sum    out  WIDTH  result, held until the next result
//     cout   out  1      final carry out, held with sum
//     ovf    out  1      signed overflow; only computed when SERIAL_ADDER_OVF_EN
//                        is defined, otherwise tied to 0
//   Latency: start accepted at edge N -> done high after edge N+WIDTH.
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   // Partial sum only needs WIDTH-1 bits: the final bit goes straight into r_sum.
   logic [WIDTH-2:0] r_sum_sr;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic [CW-1:0]    r_cnt;

   logic             w_s;
   logic             w_co;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] w_sum_next;

   fa u_fa (
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_carry),
      .sum  (w_s),
      .cout (w_co)
   );

   // start is honoured only when not busy; DONE accepts it for back-to-back adds.
   assign w_load     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last     = (r_state == S_SHIFT) && (r_cnt == LAST);
   assign w_sum_next = {w_s, r_sum_sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_sum_sr <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_a_sr  <= a;
         r_b_sr  <= b;
         r_carry <= cin;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_state <= S_SHIFT;
      end else begin
         case (r_state)
            S_SHIFT: begin
               r_sum_sr <= w_sum_next[WIDTH-1:1];
               r_carry  <= w_co;
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               if (w_last) begin
                  // Outputs update only here, on entry to DONE.
                  r_sum   <= w_sum_next;
                  r_cout  <= w_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  // Counter stops at LAST so it never wraps within an add.
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // On the last bit r_carry is the carry into the MSB and w_co the carry out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (!w_load && w_last) begin
         r_ovf <= r_carry ^ w_co;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
